btc_enc_buf_ctrl: RTL and testbench
===================================

Name: btc_enc_buf_ctrl

Overview:
- Bank controller for the BTC encoder input buffer, which holds pBANK_NUM frame banks.
- Sequences the bitserial source (writer) and the encoder engine (reader) over the shared buffer.
  - Tracks which banks are filled.
  - Latches the code mode of each frame.
  - Starts the engine on the oldest filled bank.
  - Drives the almost-full/empty flags the source uses for its ready/busy outputs.

Parameters:
- pBANK_NUM, 2: number of frame banks; legal values 2..8.
- pBANK_W, 1: bank index width; must equal max(1, $clog2(pBANK_NUM)).

Ports:
- iclk  input  1  clock
- ireset  input  1  reset; one clock; reset is asynchronous and active-low (0 = reset)
- iclkena  input  1  clock enable; all state holds while low
- ixmode  input  btc_code_mode_t  X code mode of the frame being written; sampled on iwfull
- iymode  input  btc_code_mode_t  Y code mode; sampled on iwfull
- ismode  input  btc_short_mode_t  shortening mode; sampled on iwfull
- iwfull  input  1  1-cycle pulse from the source: current write bank complete
- owbank  output  pBANK_W  bank currently being written (high address bits of the buffer write port)
- ofulla  output  1  all banks hold data; feeds source ifulla
- oemptya  output  1  no bank holds data and the engine is idle; feeds source iemptya
- ostart  output  1  1-cycle pulse: engine starts a frame
- orbank  output  pBANK_W  bank the engine reads; stable from ostart until idone
- oxmode  output  btc_code_mode_t  latched modes of orbank; valid while the engine runs
- oymode  output  btc_code_mode_t  (as oxmode)
- osmode  output  btc_short_mode_t  (as oxmode)
- idone  input  1  1-cycle pulse from the engine: orbank fully consumed
- oerr  output  1  sticky protocol-error flag

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, used=0, state=IDLE, ostart=0, oerr=0, mode registers=0.
  - Resulting outputs: owbank=0, orbank=0, ofulla=0, oemptya=1.
- used counts banks holding data, including the bank being processed; range 0..pBANK_NUM; width pBANK_W+1.
- iwfull with used<pBANK_NUM:
  - Store ixmode/iymode/ismode into the mode slot [wr_ptr].
  - wr_ptr advances, wrapping pBANK_NUM-1 -> 0.
  - used increments.
- iwfull with used==pBANK_NUM:
  - Ignored: no pointer or count change.
  - oerr<=1.
- ofulla = (used==pBANK_NUM), decoded from registers (combinational output).
  - Goes high the cycle after the iwfull that fills the last bank.
- oemptya = (used==0) & (state==IDLE).
- Reader FSM:
  - IDLE: if used>0 then ostart<=1 and go to RUN; orbank=rd_ptr; mode outputs = slot[rd_ptr].
  - RUN: ostart<=0. On idone: rd_ptr advances (wrapping), used decrements, go to IDLE.
- Latency:
  - iwfull in cycle t with used=0 and state IDLE -> ostart high in cycle t+2.
  - idone in cycle t with used>1 after the decrement -> next ostart in t+2.
- iwfull and idone in the same cycle: both pointers advance and used is unchanged. The write is legal even when used==pBANK_NUM before the edge.
- idone in IDLE, or in the same cycle as ostart: ignored, oerr<=1.
- oerr clears only on reset.
- iclkena low: registers hold; pulses arriving while iclkena is low are not seen.
- The mode slot at rd_ptr is never overwritten while its bank is in use; guaranteed by the used bound.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). Buffer contents are abandoned.

Optional Feature:
- Macro: BTC_ENC_BUF_CTRL_STAT_EN.
- Defined:
  - Extra output ofrm_cnt [15:0]: counts idone pulses accepted in RUN, wrapping 0xFFFF->0.
  - Extra output omax_used [pBANK_W:0]: high-water mark of used.
  - Both reset to 0.
- Undefined: neither port exists; no extra logic.

Test Plan:
- Reset -> oemptya=1, ofulla=0, ostart=0, owbank=0, orbank=0, oerr=0.
- Single frame, pBANK_NUM=2:
  - iwfull in cycle 10 with ixmode=M1 -> ostart in cycle 12, orbank=0, oxmode=M1, owbank=1, oemptya=0.
  - idone in cycle 40 -> oemptya=1 in cycle 41.
- Fill both banks with the engine held in RUN (no idone):
  - iwfull twice -> ofulla=1 the cycle after the 2nd pulse.
  - 3rd iwfull -> oerr=1, owbank unchanged.
- idone and iwfull in the same cycle at used=2 -> used stays 2, ofulla stays 1, owbank and orbank both advance; next ostart 2 cycles later carries the correct latched modes.
- Spurious idone in IDLE -> oerr=1, rd_ptr unchanged.
- Reset pulse (0) in RUN with used=2 -> all outputs return to reset values asynchronously.
- With BTC_ENC_BUF_CTRL_STAT_EN: after 5 completed frames, ofrm_cnt=5 and omax_used=2.

Source files
------------

// File: rtl/btc_enc_buf_ctrl.sv
// Bank controller for the BTC encoder input buffer: tracks filled banks, latches per-frame
// code modes and starts the engine on the oldest bank. Optional stats: BTC_ENC_BUF_CTRL_STAT_EN.
`timescale 1ns/1ps

package btc_enc_buf_ctrl_pkg;
  typedef logic [3:0] btc_code_mode_t;
  typedef logic [1:0] btc_short_mode_t;
endpackage

module btc_enc_buf_ctrl
  import btc_enc_buf_ctrl_pkg::*;
#(
  parameter int pBANK_NUM = 2,
  parameter int pBANK_W   = 1
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 iclkena,
  input  btc_code_mode_t       ixmode,
  input  btc_code_mode_t       iymode,
  input  btc_short_mode_t      ismode,
  input  logic                 iwfull,
  output logic [pBANK_W-1:0]   owbank,
  output logic                 ofulla,
  output logic                 oemptya,
  output logic                 ostart,
  output logic [pBANK_W-1:0]   orbank,
  output btc_code_mode_t       oxmode,
  output btc_code_mode_t       oymode,
  output btc_short_mode_t      osmode,
  input  logic                 idone,
`ifdef BTC_ENC_BUF_CTRL_STAT_EN
  output logic [15:0]          ofrm_cnt,
  output logic [pBANK_W:0]     omax_used,
`endif
  output logic                 oerr
);

  localparam logic [pBANK_W:0]   cFULL = (pBANK_W+1)'(pBANK_NUM);
  localparam logic [pBANK_W-1:0] cLAST = pBANK_W'(pBANK_NUM-1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [pBANK_W-1:0] ptr_inc(input logic [pBANK_W-1:0] p);
    return (p == cLAST) ? '0 : p + pBANK_W'(1);
  endfunction

  state_t                state_r, state_nxt_s;
  logic [pBANK_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [pBANK_W:0]      used_r, used_nxt_s;
  logic                  ostart_r, ostart_nxt_s;
  logic                  oerr_r;
  logic                  rd_done_s, wr_ok_s, err_s;
  btc_code_mode_t        xmode_r [pBANK_NUM];
  btc_code_mode_t        ymode_r [pBANK_NUM];
  btc_short_mode_t       smode_r [pBANK_NUM];

  // Accept/reject decisions and next occupancy; a finishing bank frees room for a same-cycle write
  always_comb begin
    rd_done_s = (state_r == RUN) & idone & ~ostart_r;
    wr_ok_s   = iwfull & ((used_r != cFULL) | rd_done_s);
    err_s     = (iwfull & ~wr_ok_s) | (idone & ~rd_done_s);
    case ({wr_ok_s, rd_done_s})
      2'b10:   used_nxt_s = used_r + (pBANK_W+1)'(1);
      2'b01:   used_nxt_s = used_r - (pBANK_W+1)'(1);
      default: used_nxt_s = used_r;
    endcase
  end

  // Reader FSM next state and start pulse
  always_comb begin
    state_nxt_s  = state_r;
    ostart_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (used_r != '0) begin
          state_nxt_s  = RUN;
          ostart_nxt_s = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      RUN: begin
        if (rd_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Pointer, occupancy, FSM and error-flag registers
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_r  <= IDLE;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      used_r   <= '0;
      ostart_r <= 1'b0;
      oerr_r   <= 1'b0;
    end else if (iclkena) begin
      state_r  <= state_nxt_s;
      ostart_r <= ostart_nxt_s;
      used_r   <= used_nxt_s;
      if (wr_ok_s)   wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (rd_done_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (err_s)     oerr_r   <= 1'b1;
    end
  end

  // Per-bank mode slots, written when the source closes a bank
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i < pBANK_NUM; i++) begin
        xmode_r[i] <= '0;
        ymode_r[i] <= '0;
        smode_r[i] <= '0;
      end
    end else if (iclkena && wr_ok_s) begin
      xmode_r[wr_ptr_r] <= ixmode;
      ymode_r[wr_ptr_r] <= iymode;
      smode_r[wr_ptr_r] <= ismode;
    end
  end

`ifdef BTC_ENC_BUF_CTRL_STAT_EN
  logic [15:0]      frm_cnt_r;
  logic [pBANK_W:0] max_used_r;

  // Completed-frame counter and occupancy high-water mark
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      frm_cnt_r  <= '0;
      max_used_r <= '0;
    end else if (iclkena) begin
      if (rd_done_s)                 frm_cnt_r  <= frm_cnt_r + 16'd1;
      if (used_nxt_s > max_used_r)   max_used_r <= used_nxt_s;
    end
  end

  assign ofrm_cnt  = frm_cnt_r;
  assign omax_used = max_used_r;
`endif

  assign owbank  = wr_ptr_r;
  assign orbank  = rd_ptr_r;
  assign ostart  = ostart_r;
  assign oerr    = oerr_r;
  assign ofulla  = (used_r == cFULL);
  assign oemptya = (used_r == '0) & (state_r == IDLE);
  assign oxmode  = xmode_r[rd_ptr_r];
  assign oymode  = ymode_r[rd_ptr_r];
  assign osmode  = smode_r[rd_ptr_r];

endmodule

// File: tb/tb_btc_enc_buf_ctrl.sv
// Directed self-checking bench for btc_enc_buf_ctrl (pBANK_NUM=2) with immediate assertions.
`timescale 1ns/1ps

module tb_btc_enc_buf_ctrl;
  import btc_enc_buf_ctrl_pkg::*;

  logic            iclk = 1'b0;
  logic            ireset, iclkena, iwfull, idone;
  btc_code_mode_t  ixmode, iymode, oxmode, oymode;
  btc_short_mode_t ismode, osmode;
  logic [0:0]      owbank, orbank;
  logic            ofulla, oemptya, ostart, oerr;
`ifdef BTC_ENC_BUF_CTRL_STAT_EN
  logic [15:0]     ofrm_cnt;
  logic [1:0]      omax_used;
`endif

  int n_chk = 0;
  int n_err = 0;

  btc_enc_buf_ctrl #(.pBANK_NUM(2), .pBANK_W(1)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .ixmode(ixmode), .iymode(iymode), .ismode(ismode), .iwfull(iwfull),
    .owbank(owbank), .ofulla(ofulla), .oemptya(oemptya), .ostart(ostart),
    .orbank(orbank), .oxmode(oxmode), .oymode(oymode), .osmode(osmode),
    .idone(idone),
`ifdef BTC_ENC_BUF_CTRL_STAT_EN
    .ofrm_cnt(ofrm_cnt), .omax_used(omax_used),
`endif
    .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic [3:0] x, input logic [3:0] y, input logic [1:0] s);
    ixmode = x; iymode = y; ismode = s;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_oemptya"}, 32'(oemptya), 32'd1);
    chk({pfx, "_ofulla"},  32'(ofulla),  32'd0);
    chk({pfx, "_ostart"},  32'(ostart),  32'd0);
    chk({pfx, "_owbank"},  32'(owbank),  32'd0);
    chk({pfx, "_orbank"},  32'(orbank),  32'd0);
    chk({pfx, "_oerr"},    32'(oerr),    32'd0);
    chk({pfx, "_oxmode"},  32'(oxmode),  32'd0);
  endtask

  initial begin
    ireset = 1'b0; iclkena = 1'b1; iwfull = 1'b0; idone = 1'b0;
    set_mode(4'h0, 4'h0, 2'd0);
    repeat (3) tick();
    chk_reset_outputs("rst");
    ireset = 1'b1;
    repeat (2) tick();

    // single frame
    set_mode(4'h5, 4'hA, 2'd2); iwfull = 1'b1; tick(); iwfull = 1'b0;
    chk("sf_ostart_early", 32'(ostart),  32'd0);
    chk("sf_owbank",       32'(owbank),  32'd1);
    chk("sf_oemptya",      32'(oemptya), 32'd0);
    tick();
    chk("sf_ostart",  32'(ostart), 32'd1);
    chk("sf_orbank",  32'(orbank), 32'd0);
    chk("sf_oxmode",  32'(oxmode), 32'h5);
    chk("sf_oymode",  32'(oymode), 32'hA);
    chk("sf_osmode",  32'(osmode), 32'd2);
    repeat (5) tick();
    idone = 1'b1; tick(); idone = 1'b0;
    chk("sf_done_oemptya", 32'(oemptya), 32'd1);
    chk("sf_done_orbank",  32'(orbank),  32'd1);
    chk("sf_done_oerr",    32'(oerr),    32'd0);

    // fill both banks, engine held in RUN
    set_mode(4'h3, 4'hC, 2'd1); iwfull = 1'b1; tick(); iwfull = 1'b0;
    chk("fill1_ofulla", 32'(ofulla), 32'd0);
    tick();
    chk("fill_ostart", 32'(ostart), 32'd1);
    chk("fill_orbank", 32'(orbank), 32'd1);
    chk("fill_oxmode", 32'(oxmode), 32'h3);
    set_mode(4'h7, 4'h9, 2'd3); iwfull = 1'b1; tick(); iwfull = 1'b0;
    chk("fill2_ofulla", 32'(ofulla), 32'd1);
    chk("fill2_owbank", 32'(owbank), 32'd1);
    chk("fill2_oerr",   32'(oerr),   32'd0);
    set_mode(4'h2, 4'h2, 2'd1); iwfull = 1'b1; tick(); iwfull = 1'b0;
    chk("ovf_oerr",   32'(oerr),   32'd1);
    chk("ovf_owbank", 32'(owbank), 32'd1);
    chk("ovf_ofulla", 32'(ofulla), 32'd1);

    // simultaneous write and done at used=2
    set_mode(4'hE, 4'h1, 2'd0); iwfull = 1'b1; idone = 1'b1; tick(); iwfull = 1'b0; idone = 1'b0;
    chk("cc_ofulla", 32'(ofulla), 32'd1);
    chk("cc_owbank", 32'(owbank), 32'd0);
    chk("cc_orbank", 32'(orbank), 32'd0);
    chk("cc_ostart", 32'(ostart), 32'd0);
    tick();
    chk("cc_next_ostart", 32'(ostart), 32'd1);
    chk("cc_next_oxmode", 32'(oxmode), 32'h7);
    chk("cc_next_oymode", 32'(oymode), 32'h9);
    chk("cc_next_osmode", 32'(osmode), 32'd3);
    tick();
    idone = 1'b1; tick(); idone = 1'b0;
    chk("cc_done_ofulla", 32'(ofulla), 32'd0);
    chk("cc_done_orbank", 32'(orbank), 32'd1);
    tick();
    chk("cc2_ostart", 32'(ostart), 32'd1);
    chk("cc2_oxmode", 32'(oxmode), 32'hE);
    chk("cc2_oymode", 32'(oymode), 32'h1);
    chk("cc2_osmode", 32'(osmode), 32'd0);

    // async reset while running with both banks full
    set_mode(4'h6, 4'h6, 2'd2); iwfull = 1'b1; tick(); iwfull = 1'b0;
    chk("pre_rst_ofulla", 32'(ofulla), 32'd1);
    #2 ireset = 1'b0;
    #1 chk_reset_outputs("arst");
    tick(); ireset = 1'b1; tick();

    // spurious done in IDLE
    idone = 1'b1; tick(); idone = 1'b0;
    chk("spur_oerr",    32'(oerr),    32'd1);
    chk("spur_orbank",  32'(orbank),  32'd0);
    chk("spur_oemptya", 32'(oemptya), 32'd1);

    // clock enable low hides the pulse
    iclkena = 1'b0; iwfull = 1'b1; tick(); iwfull = 1'b0; iclkena = 1'b1; tick();
    chk("cke_owbank",  32'(owbank),  32'd0);
    chk("cke_oemptya", 32'(oemptya), 32'd1);
    chk("cke_ostart",  32'(ostart),  32'd0);

`ifdef BTC_ENC_BUF_CTRL_STAT_EN
    ireset = 1'b0; tick(); ireset = 1'b1; tick();
    iwfull = 1'b1; tick(); tick(); iwfull = 1'b0;
    for (int f = 0; f < 5; f++) begin
      for (int w = 0; w < 10 && !ostart; w++) tick();
      chk("stat_ostart_wait", 32'(ostart), 32'd1);
      tick();
      idone = 1'b1; iwfull = (f < 3); tick(); idone = 1'b0; iwfull = 1'b0;
    end
    chk("stat_ofrm_cnt",  32'(ofrm_cnt),  32'd5);
    chk("stat_omax_used", 32'(omax_used), 32'd2);
    chk("stat_oemptya",   32'(oemptya),   32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
